// File: rtl/riscv_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, sign fix-up.
// Define RISCV_MULDIV_FAST_MUL_EN to route multiplies through a combinational multiplier (short path).
module riscv_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);
  // Handshake: a request transfers on a rising edge with in_valid & in_ready; a result
  // transfers on a rising edge with out_valid & out_ready. kill overrides both.
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_next;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, mag_b;
  logic              sign_a, sign_b, div_zero, div_ovf;
  logic [2*XLEN-1:0] acc, acc_next;
  logic [CW-1:0]     cnt;

  logic            a_signed, b_signed, sign_a_in, sign_b_in, accept, short_in;
  logic            div_zero_in, div_ovf_in, fast_mul;
  logic [XLEN-1:0] mag_a_in, mag_b_in;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      3'd0, 3'd1, 3'd4, 3'd6: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'd2:                   a_signed = 1'b1;
      default:                ;
    endcase
  end

  assign sign_a_in   = a_signed & a[XLEN-1];
  assign sign_b_in   = b_signed & b[XLEN-1];
  assign mag_a_in    = sign_a_in ? -a : a;
  assign mag_b_in    = sign_b_in ? -b : b;
  assign div_zero_in = op[2] & (b == '0);
  assign div_ovf_in  = op[2] & ~op[0] & (a == MIN_NEG) & (&b);
`ifdef RISCV_MULDIV_FAST_MUL_EN
  assign fast_mul = ~op[2];
`else
  assign fast_mul = 1'b0;
`endif
  assign short_in  = div_zero_in | div_ovf_in | fast_mul;
  assign in_ready  = (state == IDLE) & ~kill;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = short_in ? FIX : CALC;
      CALC: if (cnt == CNT_LAST) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  // One iteration: multiply adds mag_b into the high half and shifts right;
  // divide shifts {rem, quo} left and subtracts mag_b when it fits.
  logic [XLEN:0] mul_sum, div_tmp, div_diff;
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
    div_tmp  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_tmp - {1'b0, mag_b};
    if (op_q[2])
      acc_next = {(div_diff[XLEN] ? div_tmp[XLEN-1:0] : div_diff[XLEN-1:0]),
                  acc[XLEN-2:0], ~div_diff[XLEN]};
    else
      acc_next = {mul_sum, acc[XLEN-1:1]};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quo_fix  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:         fix_result = prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:         fix_result = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:   fix_result = div_zero ? '1 : (div_ovf ? a_q : quo_fix);
      default:      fix_result = div_zero ? a_q : (div_ovf ? '0 : rem_fix);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      mag_b    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q     <= op;
          a_q      <= a;
          mag_b    <= mag_b_in;
          sign_a   <= sign_a_in;
          sign_b   <= sign_b_in;
          div_zero <= div_zero_in;
          div_ovf  <= div_ovf_in;
          cnt      <= '0;
`ifdef RISCV_MULDIV_FAST_MUL_EN
          if (fast_mul)
            acc <= {{XLEN{1'b0}}, mag_a_in} * {{XLEN{1'b0}}, mag_b_in};
          else
            acc <= {{XLEN{1'b0}}, mag_a_in};
`else
          acc <= {{XLEN{1'b0}}, mag_a_in};
`endif
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
        FIX:     result <= fix_result;
        default: ;
      endcase
    end
  end
endmodule
